// File: rtl/preg_release_queue_pkg.sv
// Shared physical-register definitions for the commit-side release queue,
// reused by the freelist and rename logic.
package preg_release_queue_pkg;

  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int REL_DEPTH = 8;

  typedef logic [PREG_W-1:0] preg_t;

  // Number of entries a release/return count encodes (3 is not a legal count).
  function automatic int unsigned cnt_to_int(input logic [1:0] n);
    return (n == 2'd3) ? 0 : int'(n);
  endfunction

endpackage

// File: rtl/preg_release_queue_ring_buf.sv
// Dual-write/dual-read circular storage with head/tail/count. The caller
// guarantees room for writes and availability for reads.
module preg_ring_buf #(
  parameter int W     = 6,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 i_wr_num,
  input  logic [W-1:0]               i_wr_data1,
  input  logic [W-1:0]               i_wr_data2,
  input  logic [1:0]                 i_rd_num,
  output logic [W-1:0]               o_rd_data1,
  output logic [W-1:0]               o_rd_data2,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  logic [W-1:0]    r_buf [DEPTH];
  logic [PTRW-1:0] r_head;
  logic [PTRW-1:0] r_tail;
  logic [CW-1:0]   r_count;
  logic [PTRW-1:0] w_head1;
  logic [PTRW-1:0] w_tail1;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  assign w_head1 = r_head + PTRW'(1);
  assign w_tail1 = r_tail + PTRW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTRW'(i_rd_num);
      r_tail  <= r_tail + PTRW'(i_wr_num);
      r_count <= r_count + CW'(i_wr_num) - CW'(i_rd_num);
    end
  end

  // Entry contents are don't-care until written, so storage is not reset.
  always_ff @(posedge clk) begin
    if (i_wr_num == 2'd1 || i_wr_num == 2'd2) r_buf[r_tail]  <= i_wr_data1;
    if (i_wr_num == 2'd2)                     r_buf[w_tail1] <= i_wr_data2;
  end

  assign o_rd_data1 = r_buf[r_head];
  assign o_rd_data2 = r_buf[w_head1];
  assign o_count    = r_count;

  a_count_le_depth: assert property (@(posedge clk) disable iff (reset)
    r_count <= CW'(DEPTH));

endmodule

// File: rtl/preg_release_queue.sv
// Buffers committed physical-register frees and drains up to two per cycle
// into the freelist; flags double-frees and overflow as sticky errors.
module preg_release_queue
  import preg_release_queue_pkg::*;
#(
  parameter int NUM_PREGS = preg_release_queue_pkg::NUM_PREGS,
  parameter int DEPTH     = REL_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   num_release,
  input  logic [$clog2(NUM_PREGS)-1:0] rel_preg1,
  input  logic [$clog2(NUM_PREGS)-1:0] rel_preg2,
  output logic [$clog2(DEPTH):0]       space,
  output logic [1:0]                   num_return,
  output logic [$clog2(NUM_PREGS)-1:0] ret_preg1,
  output logic [$clog2(NUM_PREGS)-1:0] ret_preg2,
  input  logic                         ret_ready,
  output logic                         ovf_err,
  output logic                         dfree_err
);

  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_PREGS-1:0] r_pending;
  logic                 r_ovf_err;
  logic                 r_dfree_err;

  logic [NUM_PREGS-1:0] w_pending_next;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_space;
  logic [1:0]           w_num_return;
  logic [1:0]           w_deq;
  logic [1:0]           w_enq;
  logic [PW-1:0]        w_ret1;
  logic [PW-1:0]        w_ret2;
  logic                 w_ovf_hit;
  logic                 w_dfree_hit;

  assign w_space      = CW'(DEPTH) - w_count;
  assign w_num_return = (w_count >= CW'(2)) ? 2'd2 : w_count[1:0];
  assign w_deq        = ret_ready ? w_num_return : 2'd0;

  // Room is judged on registered space only, keeping ret_ready off this path.
  assign w_ovf_hit = (num_release == 2'd3) ||
                     ((num_release != 2'd0) && (CW'(num_release) > w_space));

  always_comb begin
    w_dfree_hit = 1'b0;
    if (num_release == 2'd1 || num_release == 2'd2)
      w_dfree_hit = r_pending[rel_preg1];
    if (num_release == 2'd2)
      w_dfree_hit = w_dfree_hit || r_pending[rel_preg2] || (rel_preg1 == rel_preg2);
  end

  assign w_enq = (w_ovf_hit || w_dfree_hit) ? 2'd0 : num_release;

  // Clear returned pregs, then mark newly queued ones; they cannot overlap
  // because a re-release of a still-pending preg is rejected above.
  always_comb begin
    w_pending_next = r_pending;
    if (w_deq != 2'd0) w_pending_next[w_ret1] = 1'b0;
    if (w_deq == 2'd2) w_pending_next[w_ret2] = 1'b0;
    if (w_enq != 2'd0) w_pending_next[rel_preg1] = 1'b1;
    if (w_enq == 2'd2) w_pending_next[rel_preg2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_ovf_err   <= 1'b0;
      r_dfree_err <= 1'b0;
    end else begin
      r_pending   <= w_pending_next;
      r_ovf_err   <= r_ovf_err | w_ovf_hit;
      r_dfree_err <= r_dfree_err | w_dfree_hit;
    end
  end

  preg_ring_buf #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .i_wr_num   (w_enq),
    .i_wr_data1 (rel_preg1),
    .i_wr_data2 (rel_preg2),
    .i_rd_num   (w_deq),
    .o_rd_data1 (w_ret1),
    .o_rd_data2 (w_ret2),
    .o_count    (w_count)
  );

  assign space      = w_space;
  assign num_return = w_num_return;
  assign ret_preg1  = w_ret1;
  assign ret_preg2  = w_ret2;
  assign ovf_err    = r_ovf_err;
  assign dfree_err  = r_dfree_err;

  a_pending_matches_count: assert property (@(posedge clk) disable iff (reset)
    $countones(r_pending) == int'(w_count));

endmodule

// File: tb/tb_preg_release_queue.sv
// Directed bench for preg_release_queue: a vector table plus hand-written
// sequences for wrap-around and mid-operation reset.
module tb_preg_release_queue;

  logic       clk;
  logic       reset;
  logic [1:0] num_release;
  logic [5:0] rel_preg1;
  logic [5:0] rel_preg2;
  logic [3:0] space;
  logic [1:0] num_return;
  logic [5:0] ret_preg1;
  logic [5:0] ret_preg2;
  logic       ret_ready;
  logic       ovf_err;
  logic       dfree_err;

  int n_checks = 0;
  int n_errors = 0;

  preg_release_queue #(.NUM_PREGS(64), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .num_release (num_release),
    .rel_preg1   (rel_preg1),
    .rel_preg2   (rel_preg2),
    .space       (space),
    .num_return  (num_return),
    .ret_preg1   (ret_preg1),
    .ret_preg2   (ret_preg2),
    .ret_ready   (ret_ready),
    .ovf_err     (ovf_err),
    .dfree_err   (dfree_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for the cycle, and the outputs expected before that cycle's edge.
  typedef struct {
    int rst; int nrel; int p1; int p2; int rr;
    int e_space; int e_nr; int e_r1; int e_r2; int c1; int c2; int e_ovf; int e_df;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_space, input int e_nr,
                         input int e_r1, input int e_r2, input int c1, input int c2,
                         input int e_ovf, input int e_df);
    chk({tag, ".space"}, int'(space), e_space);
    chk({tag, ".num_return"}, int'(num_return), e_nr);
    if (c1 != 0) chk({tag, ".ret_preg1"}, int'(ret_preg1), e_r1);
    if (c2 != 0) chk({tag, ".ret_preg2"}, int'(ret_preg2), e_r2);
    chk({tag, ".ovf_err"}, int'(ovf_err), e_ovf);
    chk({tag, ".dfree_err"}, int'(dfree_err), e_df);
  endtask

  // Driver: inputs change on the falling edge, outputs are sampled there too.
  task automatic step(input int rst, input int nrel, input int p1, input int p2, input int rr);
    reset       = 1'(rst);
    num_release = 2'(nrel);
    rel_preg1   = 6'(p1);
    rel_preg2   = 6'(p2);
    ret_ready   = 1'(rr);
    @(negedge clk);
  endtask

  initial begin
    // rst nrel p1 p2 rr | space nr r1 r2 c1 c2 ovf df
    vecs[0]  = '{0, 0,  0,  0, 0,  8, 0,  0,  0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1,  5,  0, 0,  8, 0,  0,  0, 0, 0, 0, 0};
    vecs[2]  = '{0, 2,  9, 12, 0,  7, 1,  5,  0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0,  0,  0, 0,  5, 2,  5,  9, 1, 1, 0, 0};
    vecs[4]  = '{0, 0,  0,  0, 1,  5, 2,  5,  9, 1, 1, 0, 0};
    vecs[5]  = '{0, 0,  0,  0, 0,  7, 1, 12,  0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0,  0,  0, 1,  7, 1, 12,  0, 1, 0, 0, 0};
    vecs[7]  = '{0, 2, 30, 31, 0,  8, 0,  0,  0, 0, 0, 0, 0};
    vecs[8]  = '{0, 2, 32, 33, 0,  6, 2, 30, 31, 1, 1, 0, 0};
    vecs[9]  = '{0, 2, 34, 35, 0,  4, 2, 30, 31, 1, 1, 0, 0};
    vecs[10] = '{0, 2, 36, 37, 0,  2, 2, 30, 31, 1, 1, 0, 0};
    vecs[11] = '{0, 1, 40,  0, 1,  0, 2, 30, 31, 1, 1, 0, 0};
    vecs[12] = '{0, 1, 34,  0, 0,  2, 2, 32, 33, 1, 1, 1, 0};
    vecs[13] = '{1, 0,  0,  0, 0,  2, 2, 32, 33, 1, 1, 1, 1};
    vecs[14] = '{0, 0,  0,  0, 0,  8, 0,  0,  0, 0, 0, 0, 0};
    vecs[15] = '{0, 2,  3,  3, 0,  8, 0,  0,  0, 0, 0, 0, 0};
    vecs[16] = '{0, 3,  1,  2, 0,  8, 0,  0,  0, 0, 0, 0, 1};
    vecs[17] = '{1, 0,  0,  0, 0,  8, 0,  0,  0, 0, 0, 1, 1};

    reset = 1'b1; num_release = '0; rel_preg1 = '0; rel_preg2 = '0; ret_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      chk_out($sformatf("vec%0d", i), vecs[i].e_space, vecs[i].e_nr, vecs[i].e_r1,
              vecs[i].e_r2, vecs[i].c1, vecs[i].c2, vecs[i].e_ovf, vecs[i].e_df);
      step(vecs[i].rst, vecs[i].nrel, vecs[i].p1, vecs[i].p2, vecs[i].rr);
    end

    // Wrap: advance tail to 7, drain, then a dual release straddles 7 -> 0.
    step(0, 2, 1, 2, 0);
    step(0, 2, 3, 4, 0);
    step(0, 2, 5, 6, 0);
    step(0, 1, 7, 0, 0);
    chk_out("wrap_fill", 1, 2, 1, 2, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_out("wrap_last", 7, 1, 7, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_out("wrap_empty", 8, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2, 20, 21, 0);
    chk_out("wrap_pair", 6, 2, 20, 21, 1, 1, 0, 0);
    // Re-releasing a preg in the cycle it is returned is still a double free.
    step(0, 1, 20, 0, 1);
    chk_out("deq_rerelease", 8, 0, 0, 0, 0, 0, 0, 1);

    // Mid-operation reset discards four queued entries and their pending bits.
    step(1, 0, 0, 0, 0);
    step(0, 2, 10, 11, 0);
    step(0, 2, 12, 13, 0);
    chk_out("rst_pre", 4, 2, 10, 11, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_out("rst_post", 8, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2, 10, 11, 0);
    step(0, 2, 12, 13, 0);
    chk_out("rst_rerelease", 4, 2, 10, 11, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    chk_out("rst_drain", 6, 2, 12, 13, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
